// File: rtl/oflow_bbox_dispatch_pkg.sv
// oflow_bbox_dispatch_pkg: shared widths, FSM state type and elaboration helpers
// for the bbox dispatcher. The `BBOX_VECTOR_SIZE and `SET_LEN defines live here too.
`ifndef OFLOW_BBOX_DISPATCH_DEFS
`define OFLOW_BBOX_DISPATCH_DEFS
`define BBOX_VECTOR_SIZE 32
`define SET_LEN 10
`endif

package oflow_bbox_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FIRE    = 3'd2,
    FE_WAIT = 3'd3,
    DONE    = 3'd4
  } disp_state_e;

  // Width of the slot pointer for a given PE count (at least one bit).
  function automatic int slot_width(input int num_pe);
    return (num_pe <= 1) ? 1 : $clog2(num_pe);
  endfunction

  // Constant reciprocal ceil(2^shift / num_pe); folded at elaboration so the
  // set count becomes a constant multiply plus shift (a pure shift for powers of 2).
  function automatic logic [63:0] set_recip(input int num_pe, input int shift);
    return ((64'd1 << shift) + 64'(num_pe) - 64'd1) / 64'(num_pe);
  endfunction

endpackage

// File: rtl/oflow_bbox_dispatch_if.sv
// oflow_bbox_dispatch_if: DMA bbox stream (valid/ready/data) into the dispatcher.
interface oflow_bbox_dispatch_if;
  import oflow_bbox_dispatch_pkg::*;

  logic                          bbox_valid;
  logic                          bbox_ready;
  logic [`BBOX_VECTOR_SIZE-1:0]  bbox_data;

  modport master (output bbox_valid, output bbox_data, input bbox_ready);
  modport slave  (input bbox_valid, input bbox_data, output bbox_ready);
endinterface

// File: rtl/oflow_done_collector.sv
// oflow_done_collector: sticky accumulation of per-PE done_fe while collecting,
// restricted to the PEs in the current set's mask.
module oflow_done_collector
  import oflow_bbox_dispatch_pkg::*;
#(
  parameter int NUM_PE = 4
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              collect,
  input  logic [NUM_PE-1:0] done_fe,
  input  logic [NUM_PE-1:0] mask,
  output logic              all_done
);

  logic [NUM_PE-1:0] sticky_r;
  logic [NUM_PE-1:0] hit_s;

  // Same-cycle done pulses count, so the FSM can leave on the edge they arrive.
  assign hit_s    = (sticky_r | done_fe) & mask;
  assign all_done = collect && (hit_s == mask);

  // Sticky register: accumulates only while collecting, otherwise held clear.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      sticky_r <= '0;
    end else if (collect) begin
      sticky_r <= hit_s;
    end else begin
      sticky_r <= '0;
    end
  end

endmodule

// File: rtl/oflow_bbox_dispatch.sv
// oflow_bbox_dispatch: splits a frame of bboxes from the DMA stream into sets of
// up to NUM_PE, fires the PEs per set and waits for all of them before the next.
// Optional feature macro: OFLOW_DISPATCH_PERF_CNT_EN adds the stall_cnt output.
module oflow_bbox_dispatch
  import oflow_bbox_dispatch_pkg::*;
#(
  parameter int NUM_PE  = 4,
  parameter int CNT_LEN = 10
) (
  input  logic                                     clk,
  input  logic                                     reset_N,
  input  logic                                     frame_start,
  input  logic [CNT_LEN-1:0]                       num_of_bboxes,
  oflow_bbox_dispatch_if.slave                     dma,
  output logic [NUM_PE-1:0][`BBOX_VECTOR_SIZE-1:0] bboxes_to_pe,
  output logic [NUM_PE-1:0]                        start_fe,
  input  logic [NUM_PE-1:0]                        done_fe,
  output logic [NUM_PE-1:0]                        pe_valid_mask,
  output logic [`SET_LEN-1:0]                      num_of_sets,
  output logic [`SET_LEN-1:0]                      set_idx,
  output logic                                     busy,
  output logic                                     done_dispatch
`ifdef OFLOW_DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                              stall_cnt
`endif
);

  localparam int          SLOT_W = slot_width(NUM_PE);
  localparam int          RSH    = CNT_LEN + 9;
  localparam logic [63:0] RECIP  = set_recip(NUM_PE, RSH);

  disp_state_e          state_r, state_nxt_s;
  logic [CNT_LEN-1:0]   remaining_r, remaining_nxt_s;
  logic [SLOT_W-1:0]    slot_r, slot_nxt_s;
  logic [NUM_PE-1:0]    mask_nxt_s;
  logic [`SET_LEN-1:0]  set_idx_nxt_s, sets_nxt_s, sets_calc_s;
  logic                 xfer_s, last_beat_s, all_done_s;

  assign xfer_s      = (state_r == LOAD) && dma.bbox_valid && dma.bbox_ready;
  assign last_beat_s = (slot_r == SLOT_W'(NUM_PE - 1)) || (remaining_r == CNT_LEN'(1));
  // ceil(n / NUM_PE) = ((n + NUM_PE - 1) * RECIP) >> RSH, exact over the count range.
  assign sets_calc_s = `SET_LEN'(((64'(num_of_bboxes) + 64'(NUM_PE - 1)) * RECIP) >> RSH);

  oflow_done_collector #(.NUM_PE(NUM_PE)) u_done_collector (
    .clk      (clk),
    .reset_N  (reset_N),
    .collect  (state_r == FE_WAIT),
    .done_fe  (done_fe),
    .mask     (pe_valid_mask),
    .all_done (all_done_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start) begin
          state_nxt_s = (num_of_bboxes == '0) ? DONE : LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (xfer_s && last_beat_s) begin
          state_nxt_s = FIRE;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      FIRE:    state_nxt_s = FE_WAIT;
      FE_WAIT: begin
        if (all_done_s) begin
          state_nxt_s = (remaining_r != '0) ? LOAD : DONE;
        end else begin
          state_nxt_s = FE_WAIT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame/set bookkeeping for the next cycle.
  always_comb begin
    remaining_nxt_s = remaining_r;
    slot_nxt_s      = slot_r;
    mask_nxt_s      = pe_valid_mask;
    set_idx_nxt_s   = set_idx;
    sets_nxt_s      = num_of_sets;
    if ((state_r == IDLE) && frame_start) begin
      remaining_nxt_s = num_of_bboxes;
      slot_nxt_s      = '0;
      mask_nxt_s      = '0;
      set_idx_nxt_s   = '0;
      sets_nxt_s      = sets_calc_s;
    end else if (xfer_s) begin
      mask_nxt_s[slot_r] = 1'b1;
      slot_nxt_s         = slot_r + SLOT_W'(1);
      remaining_nxt_s    = remaining_r - CNT_LEN'(1);
    end else if ((state_r == FE_WAIT) && all_done_s && (remaining_r != '0)) begin
      slot_nxt_s    = '0;
      mask_nxt_s    = '0;
      set_idx_nxt_s = set_idx + `SET_LEN'(1);
    end else begin
      remaining_nxt_s = remaining_r;
    end
  end

  // Counters and registered control outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      remaining_r    <= '0;
      slot_r         <= '0;
      pe_valid_mask  <= '0;
      set_idx        <= '0;
      num_of_sets    <= '0;
      dma.bbox_ready <= 1'b0;
      busy           <= 1'b0;
      start_fe       <= '0;
      done_dispatch  <= 1'b0;
    end else begin
      remaining_r    <= remaining_nxt_s;
      slot_r         <= slot_nxt_s;
      pe_valid_mask  <= mask_nxt_s;
      set_idx        <= set_idx_nxt_s;
      num_of_sets    <= sets_nxt_s;
      dma.bbox_ready <= (state_nxt_s == LOAD);
      busy           <= (state_nxt_s != IDLE);
      start_fe       <= (state_nxt_s == FIRE) ? mask_nxt_s : '0;
      done_dispatch  <= (state_nxt_s == DONE);
    end
  end

  // Per-PE bbox holding registers; only an accepted beat overwrites its slot.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      bboxes_to_pe <= '0;
    end else if (xfer_s) begin
      bboxes_to_pe[slot_r] <= dma.bbox_data;
    end else begin
      bboxes_to_pe <= bboxes_to_pe;
    end
  end

`ifdef OFLOW_DISPATCH_PERF_CNT_EN
  logic stall_tick_s;
  assign stall_tick_s = ((state_r == LOAD) && !dma.bbox_valid) || (state_r == FE_WAIT);

  // Saturating stall counter, restarted by an accepted frame_start.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      stall_cnt <= 32'd0;
    end else if ((state_r == IDLE) && frame_start) begin
      stall_cnt <= 32'd0;
    end else if (stall_tick_s && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule
